// File: rtl/filter_capture.sv
// filter_capture: pre/post-trigger capture buffer for the filter output stream.
// Circular history, magnitude trigger, oldest-first valid/ready readout.
module filter_capture #(
  parameter int DW   = 32,
  parameter int AW   = 6,
  parameter int POST = 16,
  parameter int DEC  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  input  logic [DW-1:0] thresh,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (DEC > 1) ? $clog2(DEC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_READ = 2'd3;

  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_LASTN = (AW+1)'(DEPTH-1);
  localparam logic [AW:0]   L_POST  = (AW+1)'(POST);
  localparam logic [AW:0]   L_MINF  = (AW+1)'(DEPTH-POST);
  localparam logic [CW-1:0] L_DECM  = CW'(DEC-1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic [AW:0]   r_post_cnt;
  logic [AW:0]   r_rd_cnt;
  logic [CW-1:0] r_dec_cnt;
  logic          r_trig;
  logic          r_done;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_last;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_cap;
  logic          w_acc;
  logic [DW-1:0] w_mag;
  logic          w_trig;
  logic          w_post_end;
  logic          w_to_read;
  logic          w_xfer;
  logic          w_issue;

  assign w_cap = (r_state == S_PRE) || (r_state == S_POST);
  assign w_acc = w_cap && din_en && (r_dec_cnt == '0);
  // Negation of the most negative value wraps to 2**(DW-1) as unsigned.
  assign w_mag = din[DW-1] ? (~din + DW'(1)) : din;
  assign w_trig = (r_state == S_PRE) && w_acc
               && (w_mag >= thresh) && (r_fill >= L_MINF);
  assign w_post_end = (r_state == S_POST) && w_acc
                   && ((r_post_cnt + (AW+1)'(1)) == L_POST);
  assign w_to_read = w_post_end || (w_trig && (POST == 1));
  assign w_xfer = r_valid && rd_ready;
  // Prefetch: refill the output register whenever it is empty or draining.
  assign w_issue = (r_state == S_READ) && (r_rd_cnt != L_DEPTH)
                && (!r_valid || rd_ready);

  assign busy      = (r_state != S_IDLE);
  assign triggered = r_trig;
  assign done      = r_done;
  assign rd_data   = r_data;
  assign rd_valid  = r_valid;
  assign rd_last   = r_last;

  // Sample RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc && !abort) r_mem[r_wr_ptr] <= din;
  end

  // Capture/readout state machine with registered RAM read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_rd_cnt   <= '0;
      r_dec_cnt  <= '0;
      r_trig     <= 1'b0;
      r_done     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_trig  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm) begin
              r_state   <= S_PRE;
              r_wr_ptr  <= '0;
              r_fill    <= '0;
              r_trig    <= 1'b0;
              r_dec_cnt <= '0;
            end
          end
          S_PRE, S_POST: begin
            if (din_en) begin
              r_dec_cnt <= (r_dec_cnt == L_DECM) ? '0
                         : r_dec_cnt + CW'(1);
            end
            if (w_acc) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              if (r_fill != L_DEPTH) r_fill <= r_fill + (AW+1)'(1);
              if (r_state == S_POST) begin
                r_post_cnt <= r_post_cnt + (AW+1)'(1);
              end
            end
            if (w_trig) begin
              r_trig     <= 1'b1;
              r_post_cnt <= (AW+1)'(1);
              r_state    <= S_POST;
            end
            if (w_to_read) begin
              r_state  <= S_READ;
              r_rd_ptr <= r_wr_ptr + AW'(1);
              r_rd_cnt <= '0;
            end
          end
          default: begin
            if (w_issue) begin
              r_data   <= r_mem[r_rd_ptr];
              r_rd_ptr <= r_rd_ptr + AW'(1);
              r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
              r_valid  <= 1'b1;
              r_last   <= (r_rd_cnt == L_LASTN);
            end else if (w_xfer) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (r_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_capture.sv
// tb_filter_capture: directed bench for filter_capture.
// dut0 runs DEC=1, dut1 runs DEC=3; both AW=4, POST=4.
module tb_filter_capture;

  typedef logic [31:0] frame_t [16];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm0 = 1'b0;
  logic        arm1 = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] din = '0;
  logic        din_en = 1'b0;
  logic [31:0] thresh = 32'd1000;
  logic        rd_ready = 1'b0;
  logic        sel = 1'b0;

  logic        busy0, trig0, done0, val0, last0;
  logic [31:0] data0;
  logic        busy1, trig1, done1, val1, last1;
  logic [31:0] data1;

  logic        busy, trig, done, val, last;
  logic [31:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  filter_capture #(.DW(32), .AW(4), .POST(4), .DEC(1)) dut0 (
    .clk(clk), .reset(reset), .arm(arm0), .abort(abort),
    .din(din), .din_en(din_en), .thresh(thresh),
    .busy(busy0), .triggered(trig0), .done(done0),
    .rd_data(data0), .rd_valid(val0), .rd_ready(rd_ready),
    .rd_last(last0)
  );

  filter_capture #(.DW(32), .AW(4), .POST(4), .DEC(3)) dut1 (
    .clk(clk), .reset(reset), .arm(arm1), .abort(abort),
    .din(din), .din_en(din_en), .thresh(thresh),
    .busy(busy1), .triggered(trig1), .done(done1),
    .rd_data(data1), .rd_valid(val1), .rd_ready(rd_ready),
    .rd_last(last1)
  );

  assign busy = sel ? busy1 : busy0;
  assign trig = sel ? trig1 : trig0;
  assign done = sel ? done1 : done0;
  assign val  = sel ? val1  : val0;
  assign last = sel ? last1 : last0;
  assign data = sel ? data1 : data0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] v);
    din = v;
    din_en = 1'b1;
    tick();
    din_en = 1'b0;
  endtask

  task automatic do_arm();
    if (sel) arm1 = 1'b1;
    else arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    arm1 = 1'b0;
  endtask

  task automatic collect(input frame_t exp, input bit toggle);
    int k = 0;
    int cyc = 0;
    int first = -1;
    int lastc = -1;
    bit stalled = 1'b0;
    logic [31:0] prev = '0;
    while (k < 16 && cyc < 300) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) chk("hold", data, prev);
      if (val && rd_ready) begin
        chk($sformatf("data[%0d]", k), data, exp[k]);
        chk($sformatf("last[%0d]", k), last, (k == 15));
        if (k == 0) first = cyc;
        lastc = cyc;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = val;
      end
      prev = data;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("xfer_count", k, 16);
    if (!toggle) chk("b2b_span", lastc - first, 15);
    chk("done_pulse", done, 1);
    chk("valid_after", val, 0);
    chk("idle_after", busy, 0);
    tick();
    chk("done_clear", done, 0);
  endtask

  task automatic run_frame1();
    frame_t exp;
    thresh = 32'd1000;
    do_arm();
    chk("busy_arm", busy, 1);
    chk("trig_arm", trig, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 14) chk("f1_trig_before", trig, 0);
      feed((i == 14) ? 32'd1000 : 32'(i));
      if (i == 14) chk("f1_trig_after", trig, 1);
      if (i == 17) chk("f1_valid_lat0", val, 0);
      if (i == 18) chk("f1_valid_lat1", val, 1);
    end
    for (int k = 0; k < 16; k++) begin
      exp[k] = (k + 2 == 14) ? 32'd1000 : 32'(k + 2);
    end
    collect(exp, 1'b0);
  endtask

  initial begin
    frame_t exp;
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_trig", trig0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid", val0, 0);
    chk("rst_last", last0, 0);
    chk("rst_data", data0, 0);
    reset = 1'b1;
    tick();

    // Basic frame, back-to-back readout
    run_frame1();

    // arm with abort in IDLE stays idle
    arm0 = 1'b1;
    abort = 1'b1;
    tick();
    arm0 = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle", busy0, 0);

    // Early crossings ignored; trigger at fill==12; toggled ready
    do_arm();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = 32'(100 + i);
      if (i == 2) v = 32'd5000;
      if (i == 11) v = 32'd3000;
      if (i == 12) v = 32'd2000;
      if (i == 12) chk("early_no_trig", trig, 0);
      feed(v);
      if (i == 2) chk("early3_no_trig", trig, 0);
      if (i == 12) chk("fill12_trig", trig, 1);
    end
    for (int k = 0; k < 16; k++) exp[k] = 32'(100 + k);
    exp[2] = 32'd5000;
    exp[11] = 32'd3000;
    exp[12] = 32'd2000;
    collect(exp, 1'b1);

    // Magnitude edges, then abort in POST
    do_arm();
    for (int i = 0; i < 12; i++) feed(32'd0);
    feed(-32'sd999);
    chk("mag_999_no_trig", trig, 0);
    thresh = 32'h8000_0000;
    feed(32'h8000_0000);
    chk("mag_min_trig", trig, 1);
    feed(32'd7);
    chk("post_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_trig", trig, 0);
    chk("abort_valid", val, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_no_done", done, 0);
    thresh = 32'd1000;

    // Decimation by 3 on dut1
    sel = 1'b1;
    do_arm();
    for (int i = 0; i < 48; i++) begin
      logic [31:0] v;
      v = 32'(i);
      if (i == 34 || i == 36) v = 32'd5000;
      feed(v);
      if (i == 34) chk("dec_skip_no_trig", trig, 0);
      if (i == 36) chk("dec_kept_trig", trig, 1);
    end
    for (int k = 0; k < 16; k++) exp[k] = 32'(3 * k);
    exp[12] = 32'd5000;
    collect(exp, 1'b0);
    sel = 1'b0;

    // Reset pulse in the middle of readout
    do_arm();
    for (int i = 0; i < 16; i++) feed((i == 12) ? 32'd1500 : 32'(200 + i));
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("mid_valid", val, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", val, 0);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_trig", trig, 0);
    chk("rst_mid_last", last, 0);
    tick();
    reset = 1'b1;
    rd_ready = 1'b0;
    tick();
    chk("rst_mid_done", done, 0);

    // Clean frame after the interrupted one
    run_frame1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
